// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bus_arbiter_pkg                                            |
// | Description : Shared definitions for the ibus/dbus memory arbiter:       |
// |               FSM state and owner encodings, default bus widths and the  |
// |               word returned to a requester whose access timed out.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package bus_arbiter_pkg;

   // Default bus widths of the core's memory interface.
   localparam int c_ADDR_BUS_W = 32;
   localparam int c_DATA_BUS_W = 32;
   localparam int c_BYTE_WEN_W = c_DATA_BUS_W / 8;

   // Marker word loaded into the owner's read-data register on a timeout.
   localparam logic [31:0] c_TIMEOUT_ERR = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_WAIT = 2'd2,
      ARB_DONE = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } arb_owner_t;

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : arb_watchdog                                               |
// | Description : Transaction watchdog for bus_arbiter. Counts cycles while  |
// |               a transaction is active and flags expiry on the last       |
// |               allowed cycle. Only instantiated with ARB_TIMEOUT_EN.      |
// | Ports       : clk, rst      - clock, async active-high reset             |
// |               i_run         - transaction in progress (REQ or WAIT)      |
// |               o_expired     - this is cycle TIMEOUT_CYC-1 of the access  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module arb_watchdog #(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic i_run,
   output logic o_expired
);

   localparam int c_CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

   logic [c_CNT_W-1:0] r_cnt;

   // Held at zero whenever no transaction is active, so every entry to REQ
   // starts a fresh count. Saturates at the last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!i_run) begin
         r_cnt <= '0;
      end else if (r_cnt != c_LAST) begin
         r_cnt <= r_cnt + c_CNT_W'(1);
      end
   end

   assign o_expired = i_run && (r_cnt == c_LAST);

endmodule : arb_watchdog
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bus_arbiter                                                |
// | Description : Shares one single-port memory interface between the        |
// |               instruction bus and the data bus. One transaction is       |
// |               outstanding at a time; dbus wins over ibus. Requesters     |
// |               stall until their own DONE cycle.                          |
// | Option      : ARB_TIMEOUT_EN - abort an access after TIMEOUT_CYC cycles  |
// |               in REQ/WAIT, return 0xDEADBEEF and pulse bus_err.          |
// | Ports       : ibus_*  - fetch request, fetched word, fetch stall         |
// |               dbus_*  - load/store request, load data, data stall        |
// |               mem_*   - latched request to memory, gnt/rvalid/rdata back |
// |               bus_err - timeout pulse (constant 0 without the option)    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W      = c_ADDR_BUS_W,
   parameter int DATA_W      = c_DATA_BUS_W,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ibus_en,
   input  logic [ADDR_W-1:0]   ibus_addr,
   output logic [DATA_W-1:0]   ibus_rdata,
   output logic                ibus_stall,
   input  logic                dbus_en,
   input  logic [ADDR_W-1:0]   dbus_addr,
   input  logic [DATA_W/8-1:0] dbus_wen,
   input  logic [DATA_W-1:0]   dbus_wdata,
   output logic [DATA_W-1:0]   dbus_rdata,
   output logic                dbus_stall,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                bus_err
);

   localparam int c_WEN_W = DATA_W / 8;

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   arb_owner_t          r_owner;
   logic [ADDR_W-1:0]   r_addr;
   logic [c_WEN_W-1:0]  r_wen;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_ibus_rdata;
   logic [DATA_W-1:0]   r_dbus_rdata;
   logic [DATA_W-1:0]   w_load_data;
   logic                w_active;
   logic                w_complete;
   logic                w_expired;
   logic                w_timeout;

   assign w_active = (r_state == ARB_REQ) || (r_state == ARB_WAIT);

   // rvalid only counts while a transaction is live; in REQ it must come
   // together with the grant. Stray rvalids in IDLE/DONE fall through here.
   assign w_complete = ((r_state == ARB_REQ)  && mem_gnt && mem_rvalid) ||
                       ((r_state == ARB_WAIT) && mem_rvalid);

   // A real completion in the expiry cycle wins over the abort.
   assign w_timeout  = w_active && w_expired && !w_complete;

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (ibus_en || dbus_en) begin
               w_state_nxt = ARB_REQ;
            end
         end
         ARB_REQ: begin
            if (w_complete || w_timeout) begin
               w_state_nxt = ARB_DONE;
            end else if (mem_gnt) begin
               w_state_nxt = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (w_complete || w_timeout) begin
               w_state_nxt = ARB_DONE;
            end
         end
         ARB_DONE: begin
            w_state_nxt = ARB_IDLE;
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Request latch and read-data capture
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner      <= OWN_NONE;
         r_addr       <= '0;
         r_wen        <= '0;
         r_wdata      <= '0;
         r_ibus_rdata <= '0;
         r_dbus_rdata <= '0;
      end else begin
         // Arbitration happens only in IDLE; dbus holds the older
         // instruction, so it goes first.
         if (r_state == ARB_IDLE) begin
            if (dbus_en) begin
               r_owner <= OWN_D;
               r_addr  <= dbus_addr;
               r_wen   <= dbus_wen;
               r_wdata <= dbus_wdata;
            end else if (ibus_en) begin
               r_owner <= OWN_I;
               r_addr  <= ibus_addr;
               r_wen   <= '0;
               r_wdata <= '0;
            end
         end else if (r_state == ARB_DONE) begin
            r_owner <= OWN_NONE;
         end

         // Captured even if the owner already dropped its enable (flush);
         // stores also update dbus_rdata, software ignores it.
         if (w_complete || w_timeout) begin
            if (r_owner == OWN_I) begin
               r_ibus_rdata <= w_load_data;
            end else if (r_owner == OWN_D) begin
               r_dbus_rdata <= w_load_data;
            end
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [DATA_W-1:0] c_ERR_WORD = DATA_W'(c_TIMEOUT_ERR);

   logic r_bus_err;

   arb_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .i_run     (w_active),
      .o_expired (w_expired)
   );

   // Registered alongside the forced DONE transition, so it is high for
   // exactly the DONE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= w_timeout;
      end
   end

   assign bus_err     = r_bus_err;
   assign w_load_data = w_timeout ? c_ERR_WORD : mem_rdata;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = (TIMEOUT_CYC == 0);
   assign w_expired        = 1'b0;
   assign bus_err          = 1'b0;
   assign w_load_data      = mem_rdata;
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   // Decoded straight from the state register so reset drops it at once.
   assign mem_req    = (r_state == ARB_REQ);
   assign mem_addr   = r_addr;
   assign mem_wen    = r_wen;
   assign mem_wdata  = r_wdata;
   assign ibus_rdata = r_ibus_rdata;
   assign dbus_rdata = r_dbus_rdata;

   assign ibus_stall = ibus_en && !((r_state == ARB_DONE) && (r_owner == OWN_I));
   assign dbus_stall = dbus_en && !((r_state == ARB_DONE) && (r_owner == OWN_D));

endmodule : bus_arbiter
`default_nettype wire
